// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for a five-stage Y86-style core: stall/bubble
// generation, halt sequencing on a retiring exception, and performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_dstM,
  input  logic        e_cnd,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic [3:0]  cpu_stat,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [3:0] S_AOK = 4'd1;
  localparam logic [3:0] S_HLT = 4'd2;
  localparam logic [3:0] S_ADR = 4'd3;
  localparam logic [3:0] S_INS = 4'd4;

  typedef enum logic [1:0] {INIT, RUN, STOP} state_t;
  state_t state;

  logic load_use, ret_pend, mispred, exc_m, exc_w, in_run;

  assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                    (E_dstM != R_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispred  = (E_icode == I_JXX) && (e_cnd == 1'b0);
  assign exc_m    = m_stat inside {S_HLT, S_ADR, S_INS};
  assign exc_w    = W_stat inside {S_HLT, S_ADR, S_INS};
  assign in_run   = (state == RUN);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    case (state)
      INIT: begin
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      RUN: begin
        F_stall  = load_use | ret_pend;
        D_stall  = load_use;
        // A load-use stall holds D, so a pending RET must not also bubble it.
        D_bubble = mispred | (ret_pend & ~load_use);
        E_bubble = mispred | load_use;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
      end
      STOP: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] cycle_nxt, retire_nxt, stall_nxt, bubble_nxt;

  assign cycle_nxt  = (state != STOP) ? sat_inc(cycle_cnt) : cycle_cnt;
  assign retire_nxt = (in_run && (W_icode != I_NOP) && (W_stat == S_AOK) && !W_stall)
                      ? sat_inc(retire_cnt) : retire_cnt;
  assign stall_nxt  = (in_run && F_stall) ? sat_inc(stall_cnt) : stall_cnt;
  assign bubble_nxt = (in_run && (D_bubble || E_bubble)) ? sat_inc(bubble_cnt) : bubble_cnt;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      cpu_stat   <= S_AOK;
      halted     <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      cycle_cnt  <= cycle_nxt;
      retire_cnt <= retire_nxt;
      stall_cnt  <= stall_nxt;
      bubble_cnt <= bubble_nxt;
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (exc_w) begin
            state    <= STOP;
            cpu_stat <= W_stat;
            halted   <= 1'b1;
          end
        end
        STOP:    state <= STOP;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard controls, halt sequencing, counter
// saturation and reset, checked against hand-computed values.
module tb_pipe_ctrl;

  logic        clk, reset;
  logic [3:0]  D_icode, E_icode, M_icode, W_icode;
  logic [3:0]  d_srcA, d_srcB, E_dstM;
  logic        e_cnd;
  logic [3:0]  m_stat, W_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [3:0]  cpu_stat;
  logic        halted;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt, bubble_cnt;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .cpu_stat(cpu_stat), .halted(halted),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum {M_INIT, M_RUN, M_STOP} mstate_t;
  mstate_t     m_state;
  logic [31:0] exp_cycle, exp_retire, exp_stall, exp_bubble;
  logic [3:0]  exp_stat;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".cycle"},  cycle_cnt,  exp_cycle);
    chk({tag, ".retire"}, retire_cnt, exp_retire);
    chk({tag, ".stall"},  stall_cnt,  exp_stall);
    chk({tag, ".bubble"}, bubble_cnt, exp_bubble);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_state == M_STOP});
    chk({tag, ".stat"},   {28'd0, cpu_stat}, {28'd0, exp_stat});
  endtask

  // One clock cycle: check controls mid-cycle against exp_ctl
  // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall}, then step the
  // expected counters/state and check them after the edge.
  task automatic cyc(input string tag, input logic [5:0] exp_ctl);
    #1;
    chk({tag, ".ctl"}, {26'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall},
        {26'd0, exp_ctl});
    if (m_state != M_STOP) exp_cycle = inc(exp_cycle);
    if (m_state == M_RUN) begin
      if (exp_ctl[5]) exp_stall = inc(exp_stall);
      if (exp_ctl[3] || exp_ctl[2]) exp_bubble = inc(exp_bubble);
      if (W_icode != 4'h1 && W_stat == 4'd1 && !exp_ctl[0]) exp_retire = inc(exp_retire);
    end
    case (m_state)
      M_INIT: m_state = M_RUN;
      M_RUN: if (W_stat >= 4'd2 && W_stat <= 4'd4) begin
        m_state  = M_STOP;
        exp_stat = W_stat;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic do_reset(input string tag, input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset      = 1'b0;
    m_state    = M_INIT;
    exp_stat   = 4'd1;
    exp_cycle  = '0;
    exp_retire = '0;
    exp_stall  = '0;
    exp_bubble = '0;
    chk_state(tag);
  endtask

  task automatic idle_inputs();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA  = 4'hF; d_srcB  = 4'hF; E_dstM  = 4'hF; e_cnd   = 1'b1;
    m_stat  = 4'd1; W_stat  = 4'd1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset("reset", 2);
    cyc("init", 6'b001110);
    cyc("idle", 6'b000000);

    E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    cyc("lu_mrmov_srcB", 6'b110100);
    E_icode = 4'hB; E_dstM = 4'h2; d_srcA = 4'h2; d_srcB = 4'hF;
    cyc("lu_popq_srcA", 6'b110100);
    E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF;
    cyc("lu_dst_none", 6'b000000);

    idle_inputs();
    E_icode = 4'h7; e_cnd = 1'b0;
    cyc("mispred", 6'b001100);
    e_cnd = 1'b1;
    cyc("jxx_taken", 6'b000000);

    idle_inputs();
    D_icode = 4'h9;
    cyc("ret_D", 6'b101000);
    D_icode = 4'h1; E_icode = 4'h9;
    cyc("ret_E", 6'b101000);
    E_icode = 4'h1; M_icode = 4'h9;
    cyc("ret_M", 6'b101000);
    M_icode = 4'h1;
    cyc("ret_done", 6'b000000);

    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h4; d_srcA = 4'h4;
    cyc("ret_and_lu", 6'b110100);
    idle_inputs();
    D_icode = 4'h9; E_icode = 4'h7; e_cnd = 1'b0;
    cyc("ret_and_mispred", 6'b101100);

    idle_inputs();
    W_icode = 4'h6;
    cyc("retire", 6'b000000);
    W_icode = 4'h6; W_stat = 4'd2;
    W_icode = 4'h1; W_stat = 4'd1;

    force dut.retire_nxt = 32'hFFFF_FFFD;
    exp_retire = 32'hFFFF_FFFD;
    cyc("preload", 6'b000000);
    release dut.retire_nxt;
    W_icode = 4'h6;
    cyc("retire_sat1", 6'b000000);
    cyc("retire_sat2", 6'b000000);
    cyc("retire_sat3", 6'b000000);

    W_icode = 4'h1; m_stat = 4'd3;
    cyc("exc_m", 6'b000010);
    m_stat = 4'd1; W_stat = 4'd3;
    cyc("exc_w", 6'b000011);
    W_stat = 4'd1; W_icode = 4'h6; E_icode = 4'h7; e_cnd = 1'b0;
    cyc("stop1", 6'b110011);
    cyc("stop2", 6'b110011);

    do_reset("reset_in_stop", 1);
    idle_inputs();
    cyc("init2", 6'b001110);
    cyc("run2", 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
